// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out bit driver.
//   piso_state_t : FSM encoding (IDLE, SHIFT)
//   cnt_w()      : bit counter width for a given word width
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_bit_driver.sv
// Parallel-in/serial-out stage feeding an enabled D flip-flop.
// Ports:
//   clk        : clock, all state on posedge
//   rst        : synchronous active-high reset
//   load_valid : upstream offers load_data
//   load_data  : WIDTH-bit word, sampled only on handshake
//   load_ready : word can be accepted this cycle
//   en         : enable to d_ff, high while a valid bit is on d
//   d          : serial data bit (registered)
//   busy       : high while shifting
//   done       : high the cycle the last bit of a word is on d
module piso_bit_driver
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             en,
  output logic             d,
  output logic             busy,
  output logic             done
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("piso_bit_driver: WIDTH must be in 2..32");
  end

  localparam int unsigned     CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  piso_state_t      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             en_q, en_d;
  logic             d_q, d_d;

  logic             accept;
  logic             last_bit;
  logic             load_first;
  logic [WIDTH-1:0] load_rest;
  logic             sreg_next;
  logic [WIDTH-1:0] sreg_shifted;

  // The first bit goes straight to d on load; the shift register keeps the
  // remaining bits aligned so the next one always sits at the send end.
  always_comb begin
    if (MSB_FIRST) begin
      load_first   = load_data[WIDTH-1];
      load_rest    = load_data << 1;
      sreg_next    = sreg_q[WIDTH-1];
      sreg_shifted = sreg_q << 1;
    end else begin
      load_first   = load_data[0];
      load_rest    = load_data >> 1;
      sreg_next    = sreg_q[0];
      sreg_shifted = sreg_q >> 1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      en_q    <= 1'b0;
      d_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      en_q    <= en_d;
      d_q     <= d_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    en_d    = en_q;
    d_d     = d_q;
    accept  = load_valid && load_ready;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          cnt_d   = CNT_LAST;
          sreg_d  = load_rest;
          en_d    = 1'b1;
          d_d     = load_first;
        end else begin
          cnt_d = '0;
          en_d  = 1'b0;
          d_d   = 1'b0;
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          cnt_d  = cnt_q - CW'(1);
          sreg_d = sreg_shifted;
          en_d   = 1'b1;
          d_d    = sreg_next;
        end else if (accept) begin
          // Reload on the last bit so back-to-back words have no gap.
          cnt_d  = CNT_LAST;
          sreg_d = load_rest;
          en_d   = 1'b1;
          d_d    = load_first;
        end else begin
          state_d = IDLE;
          en_d    = 1'b0;
          d_d     = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        d_d     = 1'b0;
      end
    endcase
  end

  // Output decode: registers only, no input-to-output path.
  always_comb begin
    last_bit   = (cnt_q == '0);
    busy       = (state_q == SHIFT);
    done       = (state_q == SHIFT) && last_bit;
    load_ready = (state_q == IDLE) || last_bit;
    en         = en_q;
    d          = d_q;
  end

endmodule

// File: tb/tb_piso_bit_driver.sv
// Self-checking bench for piso_bit_driver. Two instances share the same
// stimulus: one MSB-first, one LSB-first. Each drives a d_ff model. A
// reference model keeps a queue of the bits still to appear on d per DUT.
module tb_piso_bit_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = '0;

  logic ready0, en0, d0, busy0, done0;
  logic ready1, en1, d1, busy1, done1;
  logic ff_q0, ff_q1;

  always #5 clk = ~clk;

  piso_bit_driver #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(ready0), .en(en0), .d(d0), .busy(busy0), .done(done0)
  );

  piso_bit_driver #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(ready1), .en(en1), .d(d1), .busy(busy1), .done(done1)
  );

  // Downstream enabled D flip-flops.
  always @(posedge clk) begin
    if (rst) begin
      ff_q0 <= 1'b0;
      ff_q1 <= 1'b0;
    end else begin
      if (en0) ff_q0 <= d0;
      if (en1) ff_q1 <= d1;
    end
  end

  int   checks = 0;
  int   errors = 0;
  logic bits0[$];
  logic bits1[$];
  logic exp_q0 = 1'b0;
  logic exp_q1 = 1'b0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, update the model at the edge, check #1 later.
  task automatic step(input logic lv, input logic [7:0] dat, input logic r);
    logic acc;
    load_valid = lv;
    load_data  = dat;
    rst        = r;
    @(posedge clk);
    if (r) begin
      bits0.delete();
      bits1.delete();
      exp_q0 = 1'b0;
      exp_q1 = 1'b0;
    end else begin
      // Ready when at most the final bit of a word remains to be shown.
      acc = lv && (bits0.size() <= 1);
      if (bits0.size() > 0) begin
        exp_q0 = bits0.pop_front();
        exp_q1 = bits1.pop_front();
      end
      if (acc) begin
        for (int i = 0; i < 8; i++) begin
          bits0.push_back(dat[7-i]);
          bits1.push_back(dat[i]);
        end
      end
    end
    #1;
    chk("en_msb",    en0,    bits0.size() > 0);
    chk("d_msb",     d0,     (bits0.size() > 0) ? bits0[0] : 1'b0);
    chk("done_msb",  done0,  bits0.size() == 1);
    chk("busy_msb",  busy0,  bits0.size() > 0);
    chk("ready_msb", ready0, bits0.size() <= 1);
    chk("q_msb",     ff_q0,  exp_q0);
    chk("en_lsb",    en1,    bits1.size() > 0);
    chk("d_lsb",     d1,     (bits1.size() > 0) ? bits1[0] : 1'b0);
    chk("done_lsb",  done1,  bits1.size() == 1);
    chk("busy_lsb",  busy1,  bits1.size() > 0);
    chk("ready_lsb", ready1, bits1.size() <= 1);
    chk("q_lsb",     ff_q1,  exp_q1);
  endtask

  logic [7:0] cap0, cap1;
  int         en_cnt, done_cnt;

  initial begin
    // Reset then idle
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hFF, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // Single word 8'hA5
    step(1'b1, 8'hA5, 1'b0);
    cap0 = '0; cap1 = '0; done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cap0 = {cap0[6:0], d0};
      cap1 = {d1, cap1[7:1]};
      if (done0) done_cnt++;
      if (i < 7) step(1'b0, 8'h00, 1'b0);
    end
    chk_int("a5_msb_seq", int'(cap0), 8'hA5);
    chk_int("a5_lsb_seq", int'(cap1), 8'hA5);
    chk_int("a5_done_cnt", done_cnt, 1);
    chk("a5_done_last", done0, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("a5_en_off", en0, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // 8'h01: LSB-first sends 1 then seven 0s
    step(1'b1, 8'h01, 1'b0);
    cap1 = '0;
    for (int i = 0; i < 8; i++) begin
      cap1 = {cap1[6:0], d1};
      step(1'b0, 8'h00, 1'b0);
    end
    chk_int("h01_lsb_seq", int'(cap1), 8'h80);

    // Back-to-back F0 then 0F with load_valid held high
    en_cnt = 0; done_cnt = 0;
    step(1'b1, 8'hF0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (en0) en_cnt++;
      if (done0) done_cnt++;
      step(1'b1, 8'h0F, 1'b0);
    end
    for (int i = 0; i < 9; i++) begin
      if (en0) en_cnt++;
      if (done0) done_cnt++;
      step(1'b0, 8'h00, 1'b0);
    end
    chk_int("b2b_en_cycles", en_cnt, 16);
    chk_int("b2b_done_cnt", done_cnt, 2);

    // Backpressure: pulse on the 3rd bit is ignored
    step(1'b1, 8'h3C, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("bp_ready_low", ready0, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b0);

    // Reset mid-word after 4 bits of 8'hFF, then fresh 8'h80
    done_cnt = 0;
    step(1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (done0) done_cnt++;
      step(1'b0, 8'h00, 1'b0);
    end
    step(1'b1, 8'hAA, 1'b1);
    chk("rst_mid_en", en0, 1'b0);
    chk("rst_mid_d", d0, 1'b0);
    chk_int("rst_mid_done_cnt", done_cnt, 0);
    step(1'b1, 8'h80, 1'b0);
    cap0 = '0;
    for (int i = 0; i < 8; i++) begin
      cap0 = {cap0[6:0], d0};
      step(1'b0, 8'h00, 1'b0);
    end
    chk_int("h80_msb_seq", int'(cap0), 8'h80);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) != 0, 8'($urandom), ($urandom % 60) == 0);
    end
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
